me_fullsearch_core: RTL
=======================

# me_fullsearch_core

Parametrised full-search block-matching motion estimator. It computes the sum of absolute differences (SAD) between an N×N reference block and every candidate position inside a (N+2P-1)² search window, then reports the best motion vector and its SAD. It sits between the reference-block and search-window pixel memories, which are synchronous-read. Compared with the fixed 16×16 / ±8 estimator, it adds generic block size and search range, a start/busy/done handshake, a min_sad output, asynchronous reset and an optional early-termination threshold.

## Interface
- N, 16: block edge in pixels; power of two, ≥2.
- P, 8: search range; displacements run -P..P-1 in x and y; P is a power of two.
- PIXW, 8: pixel width in bits, unsigned.
- Derived widths:
  - W = N+2P-1: window edge.
  - C = (2P)²: candidate count.
  - AWR = 2·log2(N).
  - AWS = ceil(log2(W·W)).
  - MVW = log2(2P).
  - SADW = PIXW+2·log2(N).

Ports:
- clock, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous active-low reset.
- start, in, 1: request an estimate; sampled only in IDLE.
- early_en, in, 1: enable early termination; sampled with start.
- sad_thresh, in, SADW: early-exit threshold; sampled with start.
- busy, out, 1: high from the cycle after start is accepted through the done cycle.
- done, out, 1: one-cycle pulse; results are valid from this cycle.
- AddressR, out, AWR: reference address, row·N+col.
- R, in, PIXW: reference pixel, valid one cycle after its address.
- AddressS, out, AWS: window address, (dy+P+row)·W+(dx+P+col).
- S, in, PIXW: window pixel, valid one cycle after its address.
- motionx, motiony, out, MVW: best displacement, two's complement.
- min_sad, out, SADW: SAD at the best displacement.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on start=1.
  - RUN→FLUSH after the last address, or on early exit.
  - FLUSH→DONE after the 2-cycle pipeline drain plus compare.
  - DONE→IDLE unconditionally.
- Scan order:
  - Candidates: dy outer loop from -P to P-1, dx inner loop from -P to P-1.
  - Pixels within a candidate: row-major.
  - One R/S address pair is issued per cycle, with no bubbles between candidates.
- Arithmetic:
  - |R−S| is computed at PIXW bits.
  - The accumulator is SADW bits wide and cannot overflow. It clears at each candidate's first pixel.
- Best tracking:
  - The internal best SAD initialises to all-ones at start.
  - The best is replaced only on a strictly smaller SAD, so ties keep the earliest candidate in scan order.
- Early exit: if early_en=1 and a completed candidate's SAD < sad_thresh, that candidate becomes the result (it is necessarily the best so far) and the scan stops. Addresses already issued for later candidates are discarded.
- motionx, motiony and min_sad update only in the done cycle and hold until the next done.
- A start pulse while busy is ignored, with no queuing.
- AddressR and AddressS are registered and hold their last value in IDLE.
- Reset values: all outputs are 0 and the FSM is in IDLE.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Address k (k = 1..C·N²) is issued in cycle k.
- Data for address k is consumed in cycle k+1 and accumulated at the end of that cycle.
- Let L be the cycle that issued the winning or last candidate's final address. done=1 in cycle L+3.
  - Full scan: L = C·N², so done is in cycle C·N²+3.
  - Early exit at candidate index i = (dy+P)·2P+(dx+P): L = (i+1)·N².
- busy=1 from cycle 1 through cycle L+3. start can be re-accepted in cycle L+4.
- Addresses issued after L are don't-care.
- Reset mid-operation: outputs and FSM return to their reset values immediately (asynchronously), and no done is issued.

## Test plan
Defaults N=16, P=8. Repeat test 2 with N=4, P=2 for fast regression.
1. Assert reset_n=0 at any time, including mid-run → all outputs 0, FSM in IDLE, busy=0.
2. Unique random window; R = the window block at dx=+3, dy=-5 → motionx=4'b0011, motiony=4'b1011, min_sad=0, done in cycle 65539.
3. R=0x10 everywhere, S=0x10 everywhere (all SADs tie at 0) → motionx=motiony=4'b1000 (-8), min_sad=0.
4. Same stimulus as test 2 with early_en=1, sad_thresh=1 → candidate i=59, done in cycle 15363, motion (+3,-5), min_sad=0.
5. R=0xFF, S=0x00 everywhere → min_sad=65280, motion (-8,-8), no overflow.
6. Second start at cycle 500 of a run → ignored, done occurs once. Then reset_n=0 at cycle 1000 of a new run → no done; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/me_fullsearch_core_if.sv
// Handshake and pixel-memory bus of the full-search motion estimator.
interface me_fullsearch_core_if #(
    parameter int unsigned N    = 16,
    parameter int unsigned P    = 8,
    parameter int unsigned PIXW = 8
);
    localparam int unsigned W    = N + 2*P - 1;
    localparam int unsigned AWR  = 2*$clog2(N);
    localparam int unsigned AWS  = $clog2(W*W);
    localparam int unsigned MVW  = $clog2(2*P);
    localparam int unsigned SADW = PIXW + 2*$clog2(N);

    logic            start;
    logic            early_en;
    logic [SADW-1:0] sad_thresh;
    logic            busy;
    logic            done;
    logic [AWR-1:0]  AddressR;
    logic [PIXW-1:0] R;
    logic [AWS-1:0]  AddressS;
    logic [PIXW-1:0] S;
    logic [MVW-1:0]  motionx;
    logic [MVW-1:0]  motiony;
    logic [SADW-1:0] min_sad;

    modport master (
        output start, early_en, sad_thresh, R, S,
        input  busy, done, AddressR, AddressS, motionx, motiony, min_sad
    );

    modport slave (
        input  start, early_en, sad_thresh, R, S,
        output busy, done, AddressR, AddressS, motionx, motiony, min_sad
    );
endinterface

// File: rtl/me_fullsearch_core.sv
// Full-search block-matching motion estimator: one R/S pixel pair per cycle,
// SAD accumulated per candidate, strictly-smaller best tracking, optional early exit.
module me_fullsearch_core #(
    parameter int unsigned N    = 16,
    parameter int unsigned P    = 8,
    parameter int unsigned PIXW = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    me_fullsearch_core_if.slave bus
);
    localparam int unsigned W    = N + 2*P - 1;
    localparam int unsigned LN   = $clog2(N);
    localparam int unsigned AWR  = 2*LN;
    localparam int unsigned AWS  = $clog2(W*W);
    localparam int unsigned MVW  = $clog2(2*P);
    localparam int unsigned SADW = PIXW + 2*LN;
    localparam int unsigned CDW  = 2*MVW;
    localparam int unsigned CW   = CDW + AWR;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;      // {dy_idx, dx_idx, row, col} of the issued address
    logic            issue;
    logic            v0, v1, s1_first, s1_last;
    logic [CDW-1:0]  s1_cand, best_cand;
    logic [SADW-1:0] acc, acc_nxt, best, thresh;
    logic            early_q, fin;
    logic [PIXW-1:0] diff;
    logic            cand_done, early_hit, better, final_cand;
    logic [MVW-1:0]  nx_dy, nx_dx;
    logic [LN-1:0]   nx_row, nx_col;
    logic [AWS-1:0]  s_addr_nxt;
    logic [AWR-1:0]  addr_r_q;
    logic [AWS-1:0]  addr_s_q;
    logic            busy_q, done_q;
    logic [MVW-1:0]  mx_q, my_q;
    logic [SADW-1:0] min_sad_q;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and address-issue control.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    issue     = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (early_hit || (&cnt)) begin
                    state_nxt = FLUSH;
                end else begin
                    issue   = 1'b1;
                    cnt_nxt = cnt + CW'(1);
                end
            end
            FLUSH:   if (fin) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window address of the next pixel pair.
    always_comb begin
        {nx_dy, nx_dx, nx_row, nx_col} = cnt_nxt;
        s_addr_nxt = (AWS'(nx_dy) + AWS'(nx_row)) * AWS'(W) + AWS'(nx_dx) + AWS'(nx_col);
    end

    // Absolute difference, running SAD and candidate-complete decisions.
    always_comb begin
        diff       = (bus.R > bus.S) ? (bus.R - bus.S) : (bus.S - bus.R);
        acc_nxt    = s1_first ? SADW'(diff) : (acc + SADW'(diff));
        cand_done  = v1 && s1_last && ((state == RUN) || (state == FLUSH));
        early_hit  = cand_done && early_q && (acc_nxt < thresh);
        better     = cand_done && ((acc_nxt < best) || early_hit);
        final_cand = cand_done && (early_hit || (&s1_cand));
    end

    // Address issue, pixel pipeline, accumulator and best tracking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_cand   <= '0;
            addr_r_q  <= '0;
            addr_s_q  <= '0;
            acc       <= '0;
            best      <= '1;
            best_cand <= '0;
            thresh    <= '0;
            early_q   <= 1'b0;
            fin       <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            v0  <= issue;
            if (issue) begin
                addr_r_q <= cnt_nxt[AWR-1:0];
                addr_s_q <= s_addr_nxt;
            end
            v1       <= v0;
            s1_first <= (cnt[AWR-1:0] == '0);
            s1_last  <= &cnt[AWR-1:0];
            s1_cand  <= cnt[CW-1:AWR];
            if (v1) acc <= acc_nxt;
            if ((state == IDLE) && bus.start) begin
                best    <= '1;
                early_q <= bus.early_en;
                thresh  <= bus.sad_thresh;
            end else if (better) begin
                best      <= acc_nxt;
                best_cand <= s1_cand;
            end
            fin <= final_cand;
        end
    end

    // Registered handshake and result outputs; results load only into the done cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mx_q      <= '0;
            my_q      <= '0;
            min_sad_q <= '0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE);
            if ((state == FLUSH) && fin) begin
                // Index minus P in two's complement: P is a power of two, so flip the MSB.
                mx_q      <= best_cand[MVW-1:0] ^ MVW'(P);
                my_q      <= best_cand[CDW-1:MVW] ^ MVW'(P);
                min_sad_q <= best;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.AddressR = addr_r_q;
    assign bus.AddressS = addr_s_q;
    assign bus.motionx  = mx_q;
    assign bus.motiony  = my_q;
    assign bus.min_sad  = min_sad_q;
endmodule
